// File: rtl/pattern_detector_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package pattern_detector_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 16;

endpackage

// File: rtl/pd_history.sv
// Bit history shift register, saturating fill counter and masked pattern compare.
module pd_history #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift,
  input  logic               in_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-1:0] history_reg;
  logic [MAX_LEN-1:0] history_next;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] mask;

  assign history_next = {history_reg[MAX_LEN-2:0], in_bit};
  assign fill_inc     = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + 1'b1;

  // Only the low len bits take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign mask[gi] = (LEN_W'(gi) < len);
  end

  assign match = shift && (fill_inc >= len) && (((history_next ^ pattern) & mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history_reg <= '0;
      fill_reg    <= '0;
    end else if (clear) begin
      history_reg <= '0;
      fill_reg    <= '0;
    end else if (shift) begin
      history_reg <= history_next;
      // Non-overlapping mode: forget the bits consumed by this match.
      fill_reg    <= (match && !overlap) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Configurable serial pattern detector with IDLE/RUN control.
// Optional saturating match counter enabled by defining PATDET_COUNT_EN.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter  int MAX_LEN = DEFAULT_MAX_LEN,
  parameter  int CNT_W   = DEFAULT_CNT_W,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             state;
  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic               cfg_ok;
  logic               shift;
  logic               match;

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  // A load always wins over a coincident data bit.
  assign shift  = (state == RUN) && in_valid && !cfg_load;
  assign armed  = (state == RUN);

  pd_history #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_history (
    .clk    (clk),
    .reset  (reset),
    .clear  (cfg_load),
    .shift  (shift),
    .in_bit (in_bit),
    .pattern(pattern_reg),
    .len    (len_reg),
    .overlap(overlap_reg),
    .match  (match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pattern_reg <= '0;
      len_reg     <= '0;
      overlap_reg <= 1'b0;
      cfg_err     <= 1'b0;
      detected    <= 1'b0;
    end else begin
      detected <= match;
      if (cfg_load) begin
        if (cfg_ok) begin
          state       <= RUN;
          pattern_reg <= cfg_pattern;
          len_reg     <= cfg_len;
          overlap_reg <= cfg_overlap;
          cfg_err     <= 1'b0;
        end else begin
          state   <= IDLE;
          cfg_err <= 1'b1;
        end
      end
    end
  end

`ifdef PATDET_COUNT_EN
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (cnt_clr) begin
      count_reg <= '0;
    end else if (match && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign match_count = count_reg;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_pattern_detector;

  localparam int ML = 8;
  localparam int CW = 2;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          cfg_load = 1'b0;
  logic [ML-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_overlap = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          detected;
  logic [CW-1:0] match_count;
  logic          cfg_err;
  logic          armed;

  int total = 0;
  int bad = 0;

  // Reference model state: valid bits seen since the last clearing point.
  bit            q[$];
  bit            m_run = 0;
  bit            m_err = 0;
  bit            m_det = 0;
  bit            m_ovl = 0;
  logic [ML-1:0] m_pat = '0;
  int            m_len = 0;
  int            m_cnt = 0;

  always #5 clk = ~clk;

  pattern_detector #(
    .MAX_LEN(ML),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .detected   (detected),
    .match_count(match_count),
    .cfg_err    (cfg_err),
    .armed      (armed)
  );

  function automatic int exp_count();
`ifdef PATDET_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag);
    total++;
    assert (detected === m_det) else begin
      bad++;
      $error("FAIL %s detected got=%0b want=%0b", tag, detected, m_det);
    end
    total++;
    assert (int'(match_count) === exp_count()) else begin
      bad++;
      $error("FAIL %s match_count got=%0d want=%0d", tag, match_count, exp_count());
    end
    total++;
    assert (armed === m_run) else begin
      bad++;
      $error("FAIL %s armed got=%0b want=%0b", tag, armed, m_run);
    end
    total++;
    assert (cfg_err === m_err) else begin
      bad++;
      $error("FAIL %s cfg_err got=%0b want=%0b", tag, cfg_err, m_err);
    end
  endtask

  function automatic bit model_match();
    if (q.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++)
      if (q[q.size() - 1 - i] != m_pat[i]) return 0;
    return 1;
  endfunction

  // One clock of stimulus; the model is advanced for the same edge, then outputs are checked.
  task automatic step(input string tag, input bit load, input logic [ML-1:0] pat,
                      input int len, input bit ovl, input bit vld, input bit b, input bit clr);
    @(negedge clk);
    cfg_load    = load;
    cfg_pattern = pat;
    cfg_len     = LW'(len);
    cfg_overlap = ovl;
    in_valid    = vld;
    in_bit      = b;
    cnt_clr     = clr;
    m_det = 0;
    if (load) begin
      if (len >= 1 && len <= ML) begin
        m_run = 1; m_err = 0; m_pat = pat; m_len = len; m_ovl = ovl;
        q.delete();
      end else begin
        m_run = 0; m_err = 1;
      end
    end else if (m_run && vld) begin
      q.push_back(b);
      if (q.size() > ML) void'(q.pop_front());
      m_det = model_match();
      if (m_det && !m_ovl) q.delete();
    end
    if (clr) m_cnt = 0;
    else if (m_det && m_cnt < (1 << CW) - 1) m_cnt++;
    @(posedge clk);
    #1;
    $display("step %-10s load=%0b len=%0d vld=%0b bit=%0b clr=%0b -> det=%0b cnt=%0d armed=%0b err=%0b",
             tag, load, len, vld, b, clr, detected, match_count, armed, cfg_err);
    check(tag);
  endtask

  task automatic bits(input string tag, input logic [31:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 0, '0, 0, 0, 1, seq[i], 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    cfg_load = 0; in_valid = 0; cnt_clr = 0;
    #2 reset = 1;
    #1;
    m_run = 0; m_err = 0; m_det = 0; m_cnt = 0;
    q.delete();
    $display("reset %s -> det=%0b cnt=%0d armed=%0b err=%0b", tag, detected, match_count, armed, cfg_err);
    check(tag);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    do_reset("por");

    // Overlapping 1011 on 1011011: hits after bits 4 and 7.
    step("ld1011o", 1, 8'b1011, 4, 1, 0, 0, 0);
    bits("ovl", 32'b1011011, 7);

    // Same stream, non-overlapping: only one hit.
    step("ld1011n", 1, 8'b1011, 4, 0, 0, 0, 1);
    bits("novl", 32'b1011011, 7);

    // Rejected load: IDLE, error flag, stream ignored; then recover.
    step("ld_len0", 1, 8'b1, 0, 0, 0, 0, 0);
    bits("idle", 32'b1111, 4);
    step("ld_len9", 1, 8'b1, 9, 0, 0, 0, 0);
    step("ld_ok", 1, 8'b1, 1, 0, 0, 0, 0);

    // Single-bit pattern: back-to-back pulses, counter saturates at 3.
    step("clr", 0, '0, 0, 0, 0, 0, 1);
    bits("len1", 32'b11111, 5);
    // Load coinciding with a valid bit discards that bit.
    step("ld_vld", 1, 8'b1, 1, 1, 1, 1, 0);

    // Reset mid-pattern drops history and configuration.
    step("ld110", 1, 8'b110, 3, 1, 0, 0, 0);
    bits("pre_rst", 32'b11, 2);
    do_reset("mid");
    bits("norun", 32'b0, 1);
    step("ld110b", 1, 8'b110, 3, 1, 0, 0, 0);
    bits("post_rst", 32'b0, 1);

    // Gaps in in_valid do not break a pattern.
    step("ld101", 1, 8'b101, 3, 1, 0, 0, 1);
    step("g1", 0, '0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("gap", 0, '0, 0, 0, 0, 1, 0);
    step("g0", 0, '0, 0, 0, 1, 0, 0);
    step("gap", 0, '0, 0, 0, 0, 0, 0);
    step("g1b", 0, '0, 0, 0, 1, 1, 0);
    // Clear coinciding with a match wins.
    step("g0b", 0, '0, 0, 0, 1, 0, 0);
    step("clr_hit", 0, '0, 0, 0, 1, 1, 1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset("rnd_rst");
      end else if (r < 8) begin
        step("rnd_ld", 1, ML'($urandom), int'($urandom_range(0, 10)), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      end else begin
        step("rnd", 0, '0, 0, 0, ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 30) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
